// File: rtl/sd_wav_writer.sv
// Record-path ping-pong buffer: packs 16-bit PCM samples into an 8 KB RAM
// (two 4 KB halves) and hands each full half to the SD sector-write engine
// one 512-byte sector at a time. Sector addresses run SADDR..OADDR and wrap.
module sd_wav_writer #(
  parameter logic [31:0] SADDR      = 32'd32784,
  parameter logic [31:0] OADDR      = 32'd15269887,
  parameter int          HALF_BYTES = 4096,
  parameter int          SEC_BYTES  = 512
) (
  input  logic        SD_clk,
  input  logic        init,
  input  logic        wav_wren,
  input  logic [15:0] wav_din,
  output logic        write_SD,
  output logic [31:0] write_sec,
  input  logic        byte_rden,
  output logic [7:0]  wr_byte,
  input  logic        sec_done,
  output logic        overflow,
  output logic        busy
);

  localparam int PTR_W = $clog2(2 * HALF_BYTES);  // byte pointer over both halves
  localparam int SEC_W = $clog2(SEC_BYTES);       // byte index inside a sector

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_XFER, S_WAIT} state_e;

  state_e             state_q, state_d;
  logic [PTR_W-1:0]   wptr_q, wptr_d;
  logic [PTR_W-1:0]   rptr_q, rptr_d;
  logic [SEC_W-1:0]   secbyte_q, secbyte_d;
  logic [1:0]         half_full_q, half_full_d;
  logic               write_sd_q, write_sd_d;
  logic [31:0]        write_sec_q, write_sec_d;
  logic [7:0]         wr_byte_q, wr_byte_d;
  logic               overflow_q, overflow_d;

  // Sample RAM stored as 16-bit words: one word per sample, low byte at the even address.
  logic [15:0]        ram_q [0:HALF_BYTES-1];
  logic [15:0]        rd_word_q;

  logic               wr_target_full;
  logic               wr_accept;
  logic               wr_half_done;
  logic               rd_clear;

  // Write side: accept a sample only if the half it lands in has been drained.
  always_comb begin
    wr_target_full = half_full_q[wptr_q[PTR_W-1]];
    wr_accept      = wav_wren && !wr_target_full;
    wr_half_done   = wr_accept && (wptr_q[PTR_W-2:1] == '1);
    wptr_d         = wr_accept ? wptr_q + PTR_W'(2) : wptr_q;
    overflow_d     = overflow_q | (wav_wren & wr_target_full);
  end

  // Read FSM next state and sector-side outputs.
  always_comb begin
    // NOTE: every signal gets its hold value first so no path through the case leaves it unassigned (which would infer a latch).
    state_d     = state_q;
    rptr_d      = rptr_q;
    secbyte_d   = secbyte_q;
    write_sd_d  = write_sd_q;
    write_sec_d = write_sec_q;
    wr_byte_d   = wr_byte_q;
    rd_clear    = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (half_full_q[rptr_q[PTR_W-1]]) state_d = S_REQ;
      end
      S_REQ: begin
        write_sd_d = 1'b1;
        secbyte_d  = '0;
        state_d    = S_XFER;
      end
      S_XFER: begin
        if (byte_rden) begin
          wr_byte_d = rptr_q[0] ? rd_word_q[15:8] : rd_word_q[7:0];
          rptr_d    = rptr_q + PTR_W'(1);
          secbyte_d = secbyte_q + SEC_W'(1);
          if (secbyte_q == SEC_W'(SEC_BYTES - 1)) begin
            write_sd_d = 1'b0;
            state_d    = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        if (sec_done) begin
          write_sec_d = (write_sec_q == OADDR) ? SADDR : write_sec_q + 32'd1;
          // rptr has just crossed into the other half: the one behind it is free.
          rd_clear    = (rptr_q[PTR_W-2:0] == '0);
          state_d     = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Half flags: the reader frees the half behind rptr, the writer fills the half under wptr.
  always_comb begin
    half_full_d = half_full_q;
    if (rd_clear)     half_full_d[~rptr_q[PTR_W-1]] = 1'b0;
    if (wr_half_done) half_full_d[wptr_q[PTR_W-1]]  = 1'b1;
  end

  // Control and output registers with synchronous active-low reset.
  always_ff @(posedge SD_clk) begin
    // NOTE: non-blocking assignments so every register samples pre-edge values regardless of block ordering.
    if (!init) begin
      state_q     <= S_IDLE;
      wptr_q      <= '0;
      rptr_q      <= '0;
      secbyte_q   <= '0;
      half_full_q <= 2'b00;
      write_sd_q  <= 1'b0;
      write_sec_q <= SADDR;
      wr_byte_q   <= 8'h00;
      overflow_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      wptr_q      <= wptr_d;
      rptr_q      <= rptr_d;
      secbyte_q   <= secbyte_d;
      half_full_q <= half_full_d;
      write_sd_q  <= write_sd_d;
      write_sec_q <= write_sec_d;
      wr_byte_q   <= wr_byte_d;
      overflow_q  <= overflow_d;
    end
  end

  // RAM port: sample write plus a read of the word at the next read pointer, so the
  // word for the current byte is already registered when byte_rden arrives.
  always_ff @(posedge SD_clk) begin
    // NOTE: the RAM has no reset; stale contents are never read because a half is only read after it has been completely rewritten.
    if (init && wr_accept) ram_q[wptr_q[PTR_W-1:1]] <= wav_din;
    rd_word_q <= ram_q[rptr_d[PTR_W-1:1]];
  end

  assign write_SD  = write_sd_q;
  assign write_sec = write_sec_q;
  assign wr_byte   = wr_byte_q;
  assign overflow  = overflow_q;
  assign busy      = (state_q != S_IDLE);

endmodule

// File: tb/tb_sd_wav_writer.sv
// Bench for sd_wav_writer: directed sample bursts push expected bytes and
// sector addresses into queues; a monitor pops and compares whenever the DUT
// delivers a byte or raises a sector request.
module tb_sd_wav_writer;

  localparam logic [31:0] SADDR = 32'd32784;
  localparam logic [31:0] OADDR = 32'd32795;  // short ring so the wrap is reached

  logic        clk = 1'b0;
  logic        init, wav_wren, byte_rden, sec_done;
  logic [15:0] wav_din;
  logic        write_SD, overflow, busy;
  logic [31:0] write_sec;
  logic [7:0]  wr_byte;

  always #5 clk = ~clk;

  sd_wav_writer #(.SADDR(SADDR), .OADDR(OADDR)) dut (
    .SD_clk(clk), .init(init), .wav_wren(wav_wren), .wav_din(wav_din),
    .write_SD(write_SD), .write_sec(write_sec), .byte_rden(byte_rden),
    .wr_byte(wr_byte), .sec_done(sec_done), .overflow(overflow), .busy(busy)
  );

  int          n_total = 0;
  int          n_bad   = 0;
  logic [7:0]  exp_bytes [$];
  logic [31:0] exp_secs  [$];
  logic [7:0]  last_byte = 8'h00;
  logic [31:0] cur_sec   = SADDR;
  logic [31:0] model_sec = SADDR;
  int          acc_count = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    n_total++;
    if (act !== exp_v) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp_v);
    end
  endtask

  task automatic fail_now(input string name);
    n_total++;
    n_bad++;
    $display("FAIL %s: event did not occur", name);
  endtask

  // Expected response of one accepted sample; every full half yields 8 sector requests.
  task automatic expect_sample(input logic [15:0] v);
    exp_bytes.push_back(v[7:0]);
    exp_bytes.push_back(v[15:8]);
    acc_count++;
    if (acc_count % 2048 == 0) begin
      repeat (8) begin
        exp_secs.push_back(model_sec);
        model_sec = (model_sec == OADDR) ? SADDR : model_sec + 32'd1;
      end
    end
  endtask

  // Back-to-back samples start, start+1, ...; only the first n_acc are expected to be kept.
  task automatic write_burst(input logic [15:0] start, input int n, input int n_acc);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      wav_wren = 1'b1;
      wav_din  = start + 16'(i);
      if (i < n_acc) expect_sample(wav_din);
    end
    @(negedge clk);
    wav_wren = 1'b0;
  endtask

  // SD engine model: wait for a request, pull 512 bytes, then report completion.
  // abort_at >= 0 stops after that many bytes; spur adds ignored strobes in XFER and WAIT.
  task automatic serve_sector(input int abort_at, input bit spur, input bit gap);
    int t;
    int b;
    t = 0;
    while (write_SD !== 1'b1 && t < 20000) begin
      @(negedge clk);
      t++;
    end
    if (write_SD !== 1'b1) begin
      fail_now("sector_request_timeout");
      return;
    end
    b = 0;
    while (b < 512) begin
      if (b == abort_at) begin
        byte_rden = 1'b0;
        return;
      end
      if (gap && (b % 64 == 63)) begin
        byte_rden = 1'b0;
        @(negedge clk);
      end
      byte_rden = 1'b1;
      sec_done  = spur && (b == 100);
      @(negedge clk);
      b++;
    end
    byte_rden = 1'b0;
    sec_done  = 1'b0;
    check("write_SD_low_after_512", 32'(write_SD), 32'd0);
    check("busy_in_wait", 32'(busy), 32'd1);
    if (spur) begin
      byte_rden = 1'b1;
      repeat (2) @(negedge clk);
      byte_rden = 1'b0;
      check("wait_rden_byte_held", 32'(wr_byte), 32'(last_byte));
      check("spurious_done_sec_held", write_sec, cur_sec);
      check("wait_write_SD_low", 32'(write_SD), 32'd0);
    end
    sec_done = 1'b1;
    @(negedge clk);
    sec_done = 1'b0;
  endtask

  // Monitor: compare each delivered byte and each new sector request against the queues.
  initial begin : monitor
    logic       hit;
    logic       prev_wsd;
    logic [7:0] eb;
    prev_wsd = 1'b0;
    forever begin
      @(posedge clk);
      hit = (byte_rden === 1'b1) && (write_SD === 1'b1) && (init === 1'b1);
      @(negedge clk);
      if (hit) begin
        if (exp_bytes.size() == 0) fail_now("byte_unexpected");
        else begin
          eb = exp_bytes.pop_front();
          check("byte_stream", 32'(wr_byte), 32'(eb));
          last_byte = eb;
        end
      end
      if (write_SD === 1'b1 && prev_wsd !== 1'b1) begin
        if (exp_secs.size() == 0) fail_now("sector_unexpected");
        else begin
          cur_sec = exp_secs.pop_front();
          check("sector_addr", write_sec, cur_sec);
        end
      end
      prev_wsd = write_SD;
    end
  end

  initial begin : watchdog
    #(10 * 200000);
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end

  initial begin : stimulus
    init = 1'b0; wav_wren = 1'b0; wav_din = 16'h0; byte_rden = 1'b0; sec_done = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_write_SD", 32'(write_SD), 32'd0);
    check("rst_write_sec", write_sec, SADDR);
    check("rst_wr_byte", 32'(wr_byte), 32'd0);
    check("rst_overflow", 32'(overflow), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    init = 1'b1;

    // 1: one half of samples 0..2047, request latency, 8 sectors from SADDR.
    write_burst(16'd0, 2048, 2048);
    check("lat_edge_n_busy", 32'(busy), 32'd0);
    @(negedge clk);
    check("lat_edge_n1_write_SD", 32'(write_SD), 32'd0);
    @(negedge clk);
    check("lat_edge_n2_write_SD", 32'(write_SD), 32'd1);
    check("lat_edge_n2_write_sec", write_sec, SADDR);
    check("lat_edge_n2_busy", 32'(busy), 32'd1);
    repeat (8) serve_sector(-1, 1'b0, 1'b1);
    check("t1_next_sec", write_sec, model_sec);

    // 2: two halves with the engine stalled, then drops; drain half1, probe, drain half0.
    write_burst(16'd2048, 4096, 4096);
    check("t2_no_overflow_yet", 32'(overflow), 32'd0);
    write_burst(16'd6144, 4, 0);
    check("t2_overflow_set", 32'(overflow), 32'd1);
    repeat (8) serve_sector(-1, 1'b0, 1'b0);
    write_burst(16'hBEEF, 1, 1);
    check("t2_overflow_sticky", 32'(overflow), 32'd1);
    repeat (8) serve_sector(-1, 1'b0, 1'b0);
    check("t2_idle", 32'(busy), 32'd0);
    check("t2_next_sec_after_wrap", write_sec, model_sec);

    // 4: strobes outside their states are ignored.
    byte_rden = 1'b1;
    repeat (3) @(negedge clk);
    byte_rden = 1'b0;
    sec_done  = 1'b1;
    @(negedge clk);
    sec_done  = 1'b0;
    @(negedge clk);
    check("idle_rden_byte_held", 32'(wr_byte), 32'(last_byte));
    check("idle_done_sec_held", write_sec, model_sec);
    check("idle_busy", 32'(busy), 32'd0);
    write_burst(16'h4000, 2047, 2047);
    serve_sector(-1, 1'b1, 1'b0);
    repeat (7) serve_sector(-1, 1'b0, 1'b0);

    // 5: reset mid-transfer after 100 bytes.
    write_burst(16'h6000, 2048, 2048);
    serve_sector(100, 1'b0, 1'b0);
    init = 1'b0;
    @(negedge clk);
    init = 1'b1;
    check("midrst_write_SD", 32'(write_SD), 32'd0);
    check("midrst_write_sec", write_sec, SADDR);
    check("midrst_overflow", 32'(overflow), 32'd0);
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_wr_byte", 32'(wr_byte), 32'd0);
    exp_bytes.delete();
    exp_secs.delete();
    model_sec = SADDR;
    acc_count = 0;

    // 6: steady stream (one sample per 2-3 cycles) with a prompt engine, 10 halves.
    fork
      begin
        for (int i = 0; i < 20480; i++) begin
          @(negedge clk);
          wav_wren = 1'b1;
          wav_din  = 16'(i * 3) ^ 16'h5A5A;
          expect_sample(wav_din);
          @(negedge clk);
          wav_wren = 1'b0;
          if (i % 4 == 3) @(negedge clk);
        end
      end
      begin
        repeat (80) serve_sector(-1, 1'b0, 1'b0);
      end
    join
    check("stream_overflow", 32'(overflow), 32'd0);
    check("stream_idle", 32'(busy), 32'd0);
    check("bytes_left", 32'(exp_bytes.size()), 32'd0);
    check("secs_left", 32'(exp_secs.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
